frequency_gate_counter: RTL and testbench

Measures the frequency of an asynchronous input by counting its rising edges over a fixed gate window of GATE_CYCLES clock cycles. At the end of each window it publishes the count as a binary value. This is the stage directly upstream of the BCD converter: Frequency drives the converter's 32-bit binary input, and OverRange tells the display stage that the value will not fit in four decimal digits.

---
 rtl/freq_counter_pkg.sv | 14 +
 rtl/edge_sync.sv | 27 ++
 rtl/frequency_gate_counter.sv | 116 +++++++++++
 tb/tb_frequency_gate_counter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_counter_pkg.sv
// Shared constants and state type for the frequency counter and the display path.
package freq_counter_pkg;

    localparam int COUNT_W_DEFAULT = 32;

    // Largest value the four-digit BCD display can show.
    localparam int unsigned BCD_MAX = 9999;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

endpackage

// File: rtl/edge_sync.sv
// Synchronises an asynchronous input into the clock domain and emits a
// one-cycle pulse on each rising edge of the synchronised signal.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic SignalIn,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   history_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync_q    <= '0;
            history_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], SignalIn};
            history_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_pulse = sync_q[SYNC_STAGES-1] & ~history_q;

endmodule

// File: rtl/frequency_gate_counter.sv
// Counts rising edges of SignalIn over back-to-back gate windows of
// GATE_CYCLES clocks and publishes each window's count as Frequency.
module frequency_gate_counter
    import freq_counter_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int GATE_CYCLES = 100_000_000,
    parameter int COUNT_W     = COUNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               SignalIn,
    input  logic               Enable,
    output logic [COUNT_W-1:0] Frequency,
    output logic               Valid,
    output logic               OverRange,
    output logic               GateActive,
    output logic               dbg_state
);

    localparam int                  TIMER_W    = $clog2(GATE_CYCLES);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);
    localparam logic [COUNT_W-1:0]  COUNT_MAX  = '1;

    if (GATE_CYCLES < 2 || SYNC_STAGES < 2 || CLK_HZ < 1) begin : g_param_check
        $error("frequency_gate_counter: illegal parameter value");
    end

    // Output handshake: Valid is a one-cycle strobe with no ready/backpressure.
    // Frequency and OverRange change on the same edge and hold until the next strobe.

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [COUNT_W-1:0]   freq_q, freq_d;
    logic                 valid_q, valid_d;
    logic                 over_q, over_d;
    logic                 rise;
    logic [COUNT_W-1:0]   count_sat;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .Clock      (Clock),
        .Reset      (Reset),
        .SignalIn   (SignalIn),
        .rise_pulse (rise)
    );

    // Includes the current cycle's edge so the terminal cycle counts too.
    assign count_sat = (rise && count_q != COUNT_MAX) ? count_q + COUNT_W'(1) : count_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            count_q <= '0;
            freq_q  <= '0;
            valid_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            freq_q  <= freq_d;
            valid_q <= valid_d;
            over_q  <= over_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        freq_d  = freq_q;
        over_d  = over_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                count_d = '0;
                if (Enable) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (!Enable) begin
                    // Partial window is dropped; published result is kept.
                    state_d = IDLE;
                    timer_d = '0;
                    count_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    freq_d  = count_sat;
                    over_d  = (64'(count_sat) > 64'(BCD_MAX));
                    valid_d = 1'b1;
                    timer_d = '0;
                    count_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                    count_d = count_sat;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Frequency  = freq_q;
    assign Valid      = valid_q;
    assign OverRange  = over_q;
    assign GateActive = (state_q == MEASURE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_frequency_gate_counter.sv
// Bench for frequency_gate_counter: three instances (normal, over-range and
// saturating configurations) share one stimulus and one window-level model.
module tb_frequency_gate_counter;

    localparam int  G0 = 100;
    localparam int  G1 = 20010;
    localparam int  G2 = 600;
    localparam int  SYNC = 2;
    localparam int  MAXC = 65536;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sig = 1'b0;
    logic        en  = 1'b0;

    logic [31:0] f0, f1;
    logic [7:0]  f2;
    logic        v0, v1, v2, o0, o1, o2, g0, g1, g2, d0, d1, d2;

    logic [31:0] obs_f [3];
    logic        obs_v [3];
    logic        obs_o [3];
    logic        obs_g [3];
    logic        obs_d [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    frequency_gate_counter #(.GATE_CYCLES(G0), .COUNT_W(32)) u_dut0 (
        .Clock(clk), .Reset(rst), .SignalIn(sig), .Enable(en),
        .Frequency(f0), .Valid(v0), .OverRange(o0), .GateActive(g0), .dbg_state(d0)
    );
    frequency_gate_counter #(.GATE_CYCLES(G1), .COUNT_W(32)) u_dut1 (
        .Clock(clk), .Reset(rst), .SignalIn(sig), .Enable(en),
        .Frequency(f1), .Valid(v1), .OverRange(o1), .GateActive(g1), .dbg_state(d1)
    );
    frequency_gate_counter #(.GATE_CYCLES(G2), .COUNT_W(8)) u_dut2 (
        .Clock(clk), .Reset(rst), .SignalIn(sig), .Enable(en),
        .Frequency(f2), .Valid(v2), .OverRange(o2), .GateActive(g2), .dbg_state(d2)
    );

    assign obs_f[0] = f0;
    assign obs_f[1] = f1;
    assign obs_f[2] = {24'd0, f2};
    assign obs_v[0] = v0;
    assign obs_v[1] = v1;
    assign obs_v[2] = v2;
    assign obs_o[0] = o0;
    assign obs_o[1] = o1;
    assign obs_o[2] = o2;
    assign obs_g[0] = g0;
    assign obs_g[1] = g1;
    assign obs_g[2] = g2;
    assign obs_d[0] = d0;
    assign obs_d[1] = d1;
    assign obs_d[2] = d2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- stimulus on SignalIn ----------------
    // mode 0: square wave of sig_period, 1: held low, 2: held high, 3: random per cycle
    int sig_mode   = 1;
    int sig_period = 10;
    int sig_ph     = 0;

    always @(posedge clk) begin
        #1;
        case (sig_mode)
            0: begin
                sig_ph = (sig_ph + 1) % sig_period;
                sig    = (sig_ph < sig_period / 2);
            end
            1: sig = 1'b0;
            2: sig = 1'b1;
            default: sig = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic set_sig(input int mode, input int period);
        sig_mode   = mode;
        sig_period = period;
    endtask

    // ---------------- reference model ----------------
    // Windows are tracked by their start edge; a window's count is the number
    // of 0->1 transitions among the SignalIn samples whose edges reach the
    // counter inside the window, clipped to the counter's maximum.
    bit     sig_s [MAXC];
    int     cyc = 0;
    int     last_rst = -1;
    bit     model_live = 1'b0;
    bit     m_active [3];
    int     m_start  [3];
    bit     m_valid  [3];
    longint m_freq   [3];
    bit     m_over   [3];

    function automatic int gate_of(input int i);
        case (i)
            0: return G0;
            1: return G1;
            default: return G2;
        endcase
    endfunction

    function automatic longint max_of(input int i);
        return (i == 2) ? 64'd255 : 64'd4294967295;
    endfunction

    function automatic bit s_at(input int n);
        if (n < 0 || n <= last_rst || n >= MAXC) return 1'b0;
        return sig_s[n];
    endfunction

    function automatic longint rises(input int lo, input int hi);
        longint c;
        c = 0;
        for (int n = lo; n <= hi; n++) begin
            if (s_at(n) && !s_at(n - 1)) c++;
        end
        return c;
    endfunction

    always @(posedge clk) begin
        longint cnt;
        if (cyc < MAXC) sig_s[cyc] = sig;
        if (rst) begin
            last_rst   = cyc;
            model_live = 1'b1;
            for (int i = 0; i < 3; i++) begin
                m_active[i] = 1'b0;
                m_valid[i]  = 1'b0;
                m_freq[i]   = 0;
                m_over[i]   = 1'b0;
            end
        end else if (model_live) begin
            for (int i = 0; i < 3; i++) begin
                m_valid[i] = 1'b0;
                if (!m_active[i]) begin
                    if (en) begin
                        m_active[i] = 1'b1;
                        m_start[i]  = cyc;
                    end
                end else if (!en) begin
                    m_active[i] = 1'b0;
                end else if (cyc == m_start[i] + gate_of(i)) begin
                    cnt = rises(m_start[i] + 1 - SYNC, m_start[i] + gate_of(i) - SYNC);
                    if (cnt > max_of(i)) cnt = max_of(i);
                    m_freq[i]  = cnt;
                    m_over[i]  = (cnt > 9999);
                    m_valid[i] = 1'b1;
                    m_start[i] = cyc;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (model_live) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("valid%0d", i), 64'(obs_v[i]), 64'(m_valid[i]));
                check($sformatf("gate%0d", i), 64'(obs_g[i]), 64'(m_active[i]));
                check($sformatf("state%0d", i), 64'(obs_d[i]), 64'(m_active[i]));
                check($sformatf("freq%0d", i), 64'(obs_f[i]), 64'(m_freq[i]));
                check($sformatf("over%0d", i), 64'(obs_o[i]), 64'(m_over[i]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic vld(input int which);
        return obs_v[which];
    endfunction

    // Counts rising edges until Valid of the chosen instance is seen; returns at a negedge.
    task automatic wait_valid(input int which, input int limit, output int n);
        logic seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < limit) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = vld(which);
        end
        if (!seen) check($sformatf("valid%0d_arrives", which), 64'(seen), 64'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b1;
        set_sig(0, 10);

        // basic count and first-window latency
        wait_valid(0, 200, n);
        check("first_valid_latency", 64'(n), 64'd101);
        wait_valid(0, 200, n);
        check("valid_period", 64'(n), 64'd100);
        check("basic_freq", 64'(f0), 64'd10);
        check("basic_over", 64'(o0), 64'd0);

        // no input: held low, then held high
        set_sig(1, 10);
        wait_valid(0, 200, n);
        wait_valid(0, 200, n);
        check("held_low_freq", 64'(f0), 64'd0);
        set_sig(2, 10);
        wait_valid(0, 200, n);
        wait_valid(0, 200, n);
        check("held_high_freq", 64'(f0), 64'd0);
        @(posedge clk);
        #1 en = 1'b0;
        repeat (3) @(posedge clk);
        #1 en = 1'b1;
        wait_valid(0, 200, n);
        check("held_high_enable_rise", 64'(f0), 64'd0);

        // abort mid-window, then re-enable
        set_sig(0, 10);
        wait_valid(0, 200, n);
        wait_valid(0, 200, n);
        check("pre_abort_freq", 64'(f0), 64'd10);
        repeat (49) @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_gate", 64'(g0), 64'd0);
        check("abort_hold_freq", 64'(f0), 64'd10);
        @(posedge clk);
        #1 en = 1'b1;
        wait_valid(0, 200, n);
        check("reenable_latency", 64'(n), 64'd101);

        // reset mid-window
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_freq", 64'(f0), 64'd0);
        check("reset_valid", 64'(v0), 64'd0);
        check("reset_over", 64'(o0), 64'd0);
        check("reset_gate", 64'(g0), 64'd0);
        rst = 1'b0;
        wait_valid(0, 200, n);
        check("post_reset_latency", 64'(n), 64'd101);

        // randomized segments with occasional enable drops and resets
        for (int s = 0; s < 12; s++) begin
            int r;
            int len;
            r = $urandom_range(0, 5);
            case (r)
                0: set_sig(1, 10);
                1: set_sig(2, 10);
                2: set_sig(3, 10);
                default: set_sig(0, $urandom_range(2, 25));
            endcase
            len = $urandom_range(120, 300);
            for (int c = 0; c < len; c++) begin
                @(posedge clk);
                #1;
                en  = ($urandom_range(0, 199) != 0);
                rst = ($urandom_range(0, 599) == 0);
            end
        end

        // long windows: saturation and over-range
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b0;
        set_sig(0, 2);
        repeat (3) @(posedge clk);
        #1 en = 1'b1;
        wait_valid(2, 700, n);
        wait_valid(2, 700, n);
        check("sat_freq", 64'(f2), 64'd255);
        wait_valid(1, G1 + 50, n);
        check("overrange_freq", 64'(f1), 64'd10005);
        check("overrange_flag", 64'(o1), 64'd1);
        set_sig(0, 10);
        wait_valid(1, G1 + 50, n);
        check("inrange_flag", 64'(o1), 64'd0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
